// File: rtl/run_sequencer.sv
// run_sequencer: pulses the core Start, times each program until Ack, batch of NUM_PROGS.
// Optional RUN_SEQ_TIMEOUT_EN aborts a program that runs TIMEOUT cycles without Ack.
module run_sequencer #(
    parameter int          NUM_PROGS = 3,
    parameter int          CNT_W     = 16,
    parameter int          START_LEN = 2,
    parameter int unsigned TIMEOUT   = 16'd4000,
    parameter int          PW        = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             CoreAck,
    output logic             CoreStart,
    output logic [PW-1:0]    ProgIdx,
    output logic [CNT_W-1:0] CycleCnt,
    output logic             CntValid,
    output logic             Busy,
    output logic             Done,
    output logic             TimedOut
);

    localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [SW-1:0]    LAST_PULSE = SW'(START_LEN - 1);
    localparam logic [PW-1:0]    LAST_IDX   = PW'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TO_V       = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_REPORT,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    pulse_q, pulse_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             to_q, to_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        run_d   = run_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (Go) begin
                    idx_d   = '0;
                    to_d    = 1'b0;
                    pulse_d = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (pulse_q == LAST_PULSE) begin
                    run_d   = '0;
                    state_d = S_RUN;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            S_RUN: begin
                if (CoreAck) begin
                    cnt_d   = run_q;
                    valid_d = 1'b1;
                    state_d = S_REPORT;
                end
`ifdef RUN_SEQ_TIMEOUT_EN
                else if (run_q == TO_V) begin
                    to_d    = 1'b1;
                    cnt_d   = TO_V;
                    valid_d = 1'b1;
                    state_d = S_FIN;
                end
`endif
                else if (run_q != CNT_MAX) begin
                    run_d = run_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    pulse_d = '0;
                    state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_START);
        busy_d  = (state_d == S_START) || (state_d == S_RUN) ||
                  (state_d == S_REPORT);
        done_d  = (state_d == S_FIN);
    end

    // State and output registers, synchronous reset clears everything
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pulse_q <= '0;
            run_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            run_q   <= run_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign CoreStart = start_q;
    assign ProgIdx   = idx_q;
    assign CycleCnt  = cnt_q;
    assign CntValid  = valid_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

`ifdef RUN_SEQ_TIMEOUT_EN
    assign TimedOut = to_q;
`else
    // Without the timeout the sticky flag never sets
    logic unused_timeout;
    assign unused_timeout = ^{TO_V, to_q};
    assign TimedOut = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: core Ack models plus scoreboard of expected CntValid reports.
// Two instances: defaults (TIMEOUT=20) and START_LEN=3 / CNT_W=4.
module tb_run_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic go_a, ack_a, cs_a, val_a, busy_a, done_a, to_a;
    logic [1:0] idx_a;
    logic [15:0] cnt_a;
    logic go_b, ack_b, cs_b, val_b, busy_b, done_b, to_b;
    logic [1:0] idx_b;
    logic [3:0] cnt_b;

    run_sequencer #(.NUM_PROGS(3), .CNT_W(16), .START_LEN(2), .TIMEOUT(20)) u_a (
        .Clk(clk), .Reset(rst), .Go(go_a), .CoreAck(ack_a),
        .CoreStart(cs_a), .ProgIdx(idx_a), .CycleCnt(cnt_a), .CntValid(val_a),
        .Busy(busy_a), .Done(done_a), .TimedOut(to_a)
    );

    run_sequencer #(.NUM_PROGS(3), .CNT_W(4), .START_LEN(3), .TIMEOUT(20)) u_b (
        .Clk(clk), .Reset(rst), .Go(go_b), .CoreAck(ack_b),
        .CoreStart(cs_b), .ProgIdx(idx_b), .CycleCnt(cnt_b), .CntValid(val_b),
        .Busy(busy_b), .Done(done_b), .TimedOut(to_b)
    );

    typedef struct {
        int idx;
        int cnt;
        bit to;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   dq_a[$];
    int   dq_b[$];
    exp_t eq_a[$];
    exp_t eq_b[$];
    bit   frc_b = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Core model A: Ack in RUN cycle d+1 (d popped at each RUN entry)
    initial begin : core_a
        bit prev, run, hit;
        int cyc, d;
        ack_a = 1'b0; prev = 1'b0; run = 1'b0; cyc = 0; d = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 1'b0;
                ack_a = 1'b0;
            end else begin
                if (prev && !cs_a) begin
                    run = 1'b1;
                    cyc = 0;
                    d = (dq_a.size() != 0) ? dq_a.pop_front() : 1000000;
                end
                hit = run && (cyc == d);
                if (run) cyc++;
                if (hit) run = 1'b0;
                ack_a = hit;
            end
            prev = cs_a;
        end
    end

    // Core model B: same, plus a force to hold Ack high
    initial begin : core_b
        bit prev, run, hit;
        int cyc, d;
        ack_b = 1'b0; prev = 1'b0; run = 1'b0; cyc = 0; d = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 1'b0;
                ack_b = frc_b;
            end else begin
                if (prev && !cs_b) begin
                    run = 1'b1;
                    cyc = 0;
                    d = (dq_b.size() != 0) ? dq_b.pop_front() : 1000000;
                end
                hit = run && (cyc == d);
                if (run) cyc++;
                if (hit) run = 1'b0;
                ack_b = frc_b | hit;
            end
            prev = cs_b;
        end
    end

    // Scoreboard: every CntValid pops one expected report
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (val_a) begin
                if (eq_a.size() == 0) check("a_extra_valid", 1, 0);
                else begin
                    e = eq_a.pop_front();
                    check("a_cnt", cnt_a, e.cnt);
                    check("a_idx", idx_a, e.idx);
                    check("a_to", to_a, e.to);
                end
            end
            if (val_b) begin
                if (eq_b.size() == 0) check("b_extra_valid", 1, 0);
                else begin
                    e = eq_b.pop_front();
                    check("b_cnt", cnt_b, e.cnt);
                    check("b_idx", idx_b, e.idx);
                    check("b_to", to_b, e.to);
                end
            end
        end
    end

    task automatic load_a(input int d0, input int d1, input int d2);
        dq_a.push_back(d0); eq_a.push_back('{0, d0, 1'b0});
        dq_a.push_back(d1); eq_a.push_back('{1, d1, 1'b0});
        dq_a.push_back(d2); eq_a.push_back('{2, d2, 1'b0});
    endtask

    task automatic load_b(input int d0, input int d1, input int d2);
        dq_b.push_back(d0); eq_b.push_back('{0, (d0 > 15) ? 15 : d0, 1'b0});
        dq_b.push_back(d1); eq_b.push_back('{1, (d1 > 15) ? 15 : d1, 1'b0});
        dq_b.push_back(d2); eq_b.push_back('{2, (d2 > 15) ? 15 : d2, 1'b0});
    endtask

    // Go pulse; returns at the negedge of cycle t+1
    task automatic pulse_go_a();
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, done_a, 1);
    endtask

    task automatic wait_run_a(input int idx);
        int n = 0;
        while (!(busy_a && !cs_a && !val_a && idx_a == 2'(idx)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_reach_run", n < 100, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1; go_a = 1'b0; go_b = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset_outs", {cs_a, idx_a, cnt_a, val_a, busy_a, done_a, to_a}, 0);
        check("b_reset_outs", {cs_b, idx_b, cnt_b, val_b, busy_b, done_b, to_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic batch with Ack delays 5, 0, 10 and timing of the first program
        load_a(5, 0, 10);
        pulse_go_a();
        check("a_start_t1", cs_a, 1);
        check("a_busy_t1", busy_a, 1);
        @(negedge clk);
        check("a_start_t2", cs_a, 1);
        @(negedge clk);
        check("a_start_t3", cs_a, 0);
        n = 3;
        while (!val_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_first_valid_cycle", n, 9);
        n = 0;
        while (!(val_a && idx_a == 2'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_last_report", val_a, 1);
        @(negedge clk);
        check("a_done_after_last", done_a, 1);
        check("a_busy_after_last", busy_a, 0);
        check("a_valid_one_cycle", val_a, 0);
        repeat (3) @(negedge clk);
        check("a_fin_hold_idx", idx_a, 2);
        check("a_fin_hold_cnt", cnt_a, 10);

        // Go in FIN restarts; Go during RUN of program 1 is ignored
        load_a(3, 8, 1);
        pulse_go_a();
        check("a_restart_done_low", done_a, 0);
        check("a_restart_idx", idx_a, 0);
        wait_run_a(1);
        go_a = 1'b1;
        repeat (2) @(negedge clk);
        go_a = 1'b0;
        check("a_no_restart_idx", idx_a, 1);
        wait_done_a("a_done_batch2");
        check("a_batch2_idx", idx_a, 2);

        // Reset for one cycle during RUN of program 1
        load_a(2, 9, 4);
        pulse_go_a();
        wait_run_a(1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("a_midreset_outs", {cs_a, idx_a, cnt_a, val_a, busy_a, done_a, to_a}, 0);
        rst = 1'b0;
        dq_a.delete();
        eq_a.delete();
        @(negedge clk);
        check("a_idle_after_reset", {busy_a, done_a, cs_a}, 0);
        load_a(1, 1, 1);
        pulse_go_a();
        check("a_post_reset_idx", idx_a, 0);
        check("a_post_reset_start", cs_a, 1);
        wait_done_a("a_done_batch3");

`ifdef RUN_SEQ_TIMEOUT_EN
        // Hung core: timeout after 20 RUN cycles, batch aborts at program 0
        dq_a.push_back(1000000);
        eq_a.push_back('{0, 20, 1'b1});
        pulse_go_a();
        wait_done_a("a_done_timeout");
        check("a_timedout", to_a, 1);
        check("a_to_idx", idx_a, 0);
        check("a_to_cnt", cnt_a, 20);
        check("a_to_busy", busy_a, 0);
        dq_a.delete();
        load_a(1, 2, 3);
        pulse_go_a();
        check("a_to_cleared", to_a, 0);
        wait_done_a("a_done_after_to");
`endif

        // START_LEN=3 with Ack held high through START; CNT_W=4 saturation
        frc_b = 1'b1;
        load_b(0, 30, 2);
        @(negedge clk);
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
        check("b_start_t1", cs_b, 1);
        @(negedge clk);
        check("b_start_t2", cs_b, 1);
        @(negedge clk);
        check("b_start_t3", cs_b, 1);
        @(negedge clk);
        check("b_start_t4", cs_b, 0);
        frc_b = 1'b0;
        n = 0;
        while (!done_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b_done", done_b, 1);
        check("b_final_cnt", cnt_b, 2);
        check("b_final_idx", idx_b, 2);

        repeat (2) @(negedge clk);
        check("a_scoreboard_drained", eq_a.size(), 0);
        check("b_scoreboard_drained", eq_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
